// File: rtl/pid_pipe_ctrl.sv
// Pipelined PID heading controller: saturated error in, clamped left/right wheel commands out.
// Four register stages (capture, terms, mix, output), one sample per cycle, no stalls.
module pid_pipe_ctrl #(
    parameter int ERR_W     = 12,
    parameter int SAT_W     = 10,
    parameter int FRWRD_W   = 10,
    parameter int SPD_W     = 11,
    parameter int PID_W     = 14,
    parameter int I_W       = 15,
    parameter int I_SHIFT   = 6,
    parameter int P_COEFF   = 8,
    parameter int D_COEFF   = 11,
    parameter int D_SAT_W   = 7,
    parameter int D_LAG     = 1,
    parameter int OUT_SHIFT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    moving,
    input  logic                    err_vld,
    input  logic signed [ERR_W-1:0] error,
    input  logic [FRWRD_W-1:0]      frwrd,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    spd_vld
);
    localparam int STAGES = 3;
    localparam int SAT_HI = 2**(SAT_W-1) - 1;
    localparam int I_HI   = 2**(I_W-1) - 1;
    localparam int D_HI   = 2**(D_SAT_W-1) - 1;
    localparam int PID_HI = 2**(PID_W-1) - 1;
    localparam int SPD_HI = 2**(SPD_W-1) - 1;

    function automatic int clamp(input int v, input int hi);
        if (v > hi)
            return hi;
        else if (v < -hi - 1)
            return -hi - 1;
        else
            return v;
    endfunction

    logic [STAGES:1] vld_pipe;

    // S1 capture
    logic signed [SAT_W-1:0] err_s1;
    logic [FRWRD_W-1:0]      frwrd_s1;
    logic                    moving_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_s1      <= '0;
            frwrd_s1    <= '0;
            moving_s1   <= 1'b0;
            vld_pipe[1] <= 1'b0;
        end else begin
            err_s1      <= SAT_W'(clamp(int'(error), SAT_HI));
            frwrd_s1    <= frwrd;
            moving_s1   <= moving;
            vld_pipe[1] <= err_vld;
        end
    end

    // S2 terms
    logic signed [I_W-1:0]                 acc;
    logic signed [D_LAG-1:0][SAT_W-1:0]    hist;
    logic signed [PID_W-1:0]               p_s2, i_s2, d_s2;
    logic [FRWRD_W-1:0]                    frwrd_s2;
    logic                                  moving_s2;
    int                                    acc_nxt, p_c, i_c, d_c;

    always_comb begin
        acc_nxt = clamp(int'(acc) + int'(err_s1), I_HI);
        p_c     = int'(err_s1) * P_COEFF;
        i_c     = acc_nxt >>> I_SHIFT;
        d_c     = clamp(int'(err_s1) - int'($signed(hist[D_LAG-1])), D_HI) * D_COEFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            hist <= '0;
        end else if (!moving_s1) begin
            acc  <= '0;
            hist <= '0;
        end else if (vld_pipe[1]) begin
            acc     <= I_W'(acc_nxt);
            hist[0] <= err_s1;
            for (int k = 1; k < D_LAG; k++)
                hist[k] <= hist[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_s2        <= '0;
            i_s2        <= '0;
            d_s2        <= '0;
            frwrd_s2    <= '0;
            moving_s2   <= 1'b0;
            vld_pipe[2] <= 1'b0;
        end else begin
            p_s2        <= PID_W'(p_c);
            i_s2        <= PID_W'(i_c);
            d_s2        <= PID_W'(d_c);
            frwrd_s2    <= frwrd_s1;
            moving_s2   <= moving_s1;
            vld_pipe[2] <= vld_pipe[1];
        end
    end

    // S3 mix: saturate the PID sum, then scale down before wheel mixing
    logic signed [PID_W-1:0] pid_s3;
    logic [FRWRD_W-1:0]      frwrd_s3;
    logic                    moving_s3;
    int                      pid_c;

    always_comb begin
        pid_c = clamp(int'(p_s2) + int'(i_s2) + int'(d_s2), PID_HI) >>> OUT_SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pid_s3      <= '0;
            frwrd_s3    <= '0;
            moving_s3   <= 1'b0;
            vld_pipe[3] <= 1'b0;
        end else begin
            pid_s3      <= PID_W'(pid_c);
            frwrd_s3    <= frwrd_s2;
            moving_s3   <= moving_s2;
            vld_pipe[3] <= vld_pipe[2];
        end
    end

    // Output registers hold between samples
    int lft_c, rght_c;

    always_comb begin
        lft_c  = 0;
        rght_c = 0;
        if (moving_s3) begin
            lft_c  = clamp(int'(frwrd_s3) + int'(pid_s3), SPD_HI);
            rght_c = clamp(int'(frwrd_s3) - int'(pid_s3), SPD_HI);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else begin
            spd_vld <= vld_pipe[3];
            if (vld_pipe[3]) begin
                lft_spd  <= SPD_W'(lft_c);
                rght_spd <= SPD_W'(rght_c);
            end
        end
    end
endmodule

// File: tb/tb_pid_pipe_ctrl.sv
// Directed bench for pid_pipe_ctrl: hand-computed wheel commands for D_LAG=1 and D_LAG=2 builds.
module tb_pid_pipe_ctrl;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               moving;
    logic               err_vld;
    logic signed [11:0] error;
    logic [9:0]         frwrd;
    logic signed [10:0] lft_spd, rght_spd, lft2, rght2;
    logic               spd_vld, vld2;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int ql[$], qr[$], q2l[$], q2r[$];

    always #5 clk = ~clk;

    pid_pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .moving(moving), .err_vld(err_vld),
        .error(error), .frwrd(frwrd),
        .lft_spd(lft_spd), .rght_spd(rght_spd), .spd_vld(spd_vld)
    );

    pid_pipe_ctrl #(.D_LAG(2)) dut_lag2 (
        .clk(clk), .rst_n(rst_n), .moving(moving), .err_vld(err_vld),
        .error(error), .frwrd(frwrd),
        .lft_spd(lft2), .rght_spd(rght2), .spd_vld(vld2)
    );

    always @(negedge clk) begin
        if (spd_vld) begin
            pulses++;
            ql.push_back(int'(lft_spd));
            qr.push_back(int'(rght_spd));
        end
        if (vld2) begin
            q2l.push_back(int'(lft2));
            q2r.push_back(int'(rght2));
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // all drive tasks start and end on a falling edge
    task automatic send(input int e, input int f);
        error   = 12'(e);
        frwrd   = 10'(f);
        err_vld = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        err_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        err_vld = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ql.delete(); qr.delete(); q2l.delete(); q2r.delete();
    endtask

    initial begin
        rst_n = 1'b0; moving = 1'b0; err_vld = 1'b0; error = '0; frwrd = '0;
        repeat (2) @(negedge clk);
        chk("rst_lft", int'(lft_spd), 0);
        chk("rst_rght", int'(rght_spd), 0);
        chk("rst_vld", int'(spd_vld), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single sample with latency check
        moving = 1'b1;
        send(100, 256);
        idle(1); chk("lat_n1", int'(spd_vld), 0);
        idle(1); chk("lat_n2", int'(spd_vld), 0);
        idle(1); chk("lat_n3", int'(spd_vld), 1);
        chk("single_lft", int'(lft_spd), 442);
        chk("single_rght", int'(rght_spd), 70);
        idle(1); chk("pulse_one", int'(spd_vld), 0);
        chk("hold_lft", int'(lft_spd), 442);
        chk("hold_rght", int'(rght_spd), 70);

        // positive saturation
        do_reset();
        send(2047, 1000); idle(3);
        chk("satp_vld", int'(spd_vld), 1);
        chk("satp_lft", int'(lft_spd), 1023);
        chk("satp_rght", int'(rght_spd), 402);

        // negative saturation
        do_reset();
        send(-2048, 0); idle(3);
        chk("satn_lft", int'(lft_spd), -601);
        chk("satn_rght", int'(rght_spd), 601);

        // integrator clamp, then moving drop
        do_reset();
        for (int k = 0; k < 40; k++) send(511, 256);
        moving = 1'b0; send(511, 256);
        moving = 1'b1; send(0, 300);
        idle(4);
        chk("int_count", ql.size(), 42);
        if (ql.size() == 42) begin
            chk("int_s1_lft", ql[0], 854);   chk("int_s1_rght", qr[0], -342);
            chk("int_s2_lft", ql[1], 768);   chk("int_s2_rght", qr[1], -256);
            chk("int_s33_lft", ql[32], 798); chk("int_s33_rght", qr[32], -286);
            chk("int_s40_lft", ql[39], 798); chk("int_s40_rght", qr[39], -286);
            chk("drop_lft", ql[40], 0);      chk("drop_rght", qr[40], 0);
            chk("resume_lft", ql[41], 300);  chk("resume_rght", qr[41], 300);
        end

        // D_LAG=2: gap between samples must not advance history
        do_reset();
        send(0, 256); send(40, 256);
        idle(2);
        send(80, 256);
        idle(4);
        chk("lag2_count", q2l.size(), 3);
        if (q2l.size() == 3) begin
            chk("lag2_s1_lft", q2l[0], 256); chk("lag2_s1_rght", q2r[0], 256);
            chk("lag2_s2_lft", q2l[1], 351); chk("lag2_s2_rght", q2r[1], 161);
            chk("lag2_s3_lft", q2l[2], 422); chk("lag2_s3_rght", q2r[2], 90);
        end

        // async reset with samples in flight
        do_reset();
        send(100, 256); idle(3);
        chk("pre_rst_lft", int'(lft_spd), 442);
        send(200, 256); send(200, 256);
        begin
            int snap;
            rst_n = 1'b0;
            #1;
            chk("arst_lft", int'(lft_spd), 0);
            chk("arst_rght", int'(rght_spd), 0);
            chk("arst_vld", int'(spd_vld), 0);
            snap = pulses;
            @(negedge clk);
            rst_n = 1'b1;
            idle(6);
            chk("arst_no_pulse", pulses, snap);
            chk("arst_hold_lft", int'(lft_spd), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
